// File: rtl/demux_route.sv
// -----------------------------------------------------------------------------
// demux_route
//
// Purpose:
//   1-to-2 routing demultiplexer. A single source stream is steered word by
//   word to destination 0 or destination 1 according to in_sel. Each
//   destination owns a small FIFO, so a stalled consumer only back-pressures
//   words aimed at it and never blocks words already queued for the other.
//
// Parameters:
//   WIDTH  data word width in bits
//   DEPTH  entries per destination FIFO (power of two, >= 2)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (clears FIFOs and storage)
//   in_valid    source word present
//   in_data     source word
//   in_sel      destination select: 0 -> out0, 1 -> out1
//   in_ready    word accepted this cycle if in_valid is also high
//   out0_valid  FIFO0 non-empty
//   out0_data   FIFO0 head word
//   out0_ready  consumer 0 takes the head this cycle
//   out1_valid  FIFO1 non-empty
//   out1_data   FIFO1 head word
//   out1_ready  consumer 1 takes the head this cycle
//   cnt0, cnt1  (only with DEMUX_ROUTE_CNT_EN) words accepted per FIFO,
//               wrapping 32-bit counters
//
// Optional feature macro: DEMUX_ROUTE_CNT_EN
//   Defined   -> adds cnt0/cnt1 acceptance counters.
//   Undefined -> ports and counter logic are absent.
// -----------------------------------------------------------------------------
module demux_route #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready
`ifdef DEMUX_ROUTE_CNT_EN
  ,
  output logic [31:0]      cnt0,
  output logic [31:0]      cnt1
`endif
);

  // Pointer width; a power-of-two DEPTH lets pointers wrap naturally.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Count must hold the value DEPTH itself, hence one extra bit.
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]       w_full;
  logic [1:0]       w_empty;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_out_ready;
  logic [WIDTH-1:0] w_head [2];
  logic             w_sel_full;

  assign w_out_ready = {out1_ready, out0_ready};

  // Readiness only looks at the selected FIFO's fullness: a full FIFO refuses
  // a push even when it is popping in the same cycle (no pass-through), which
  // keeps in_ready free of any combinational path from outN_ready. Gating with
  // rst_n holds in_ready low for the whole reset interval.
  assign w_sel_full = in_sel ? w_full[1] : w_full[0];
  assign in_ready   = rst_n & ~w_sel_full;

  // A push only targets the selected destination.
  assign w_push[0] = in_valid & in_ready & ~in_sel;
  assign w_push[1] = in_valid & in_ready &  in_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wr_ptr;
      logic [AW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_count;

      // A ready consumer facing an empty FIFO is simply ignored.
      assign w_pop[gi]   = ~w_empty[gi] & w_out_ready[gi];
      assign w_full[gi]  = (r_count == CW'(DEPTH));
      assign w_empty[gi] = (r_count == '0);
      // Head is read straight from storage: a word written at edge k shows up
      // after edge k, with no same-cycle bypass from in_data.
      assign w_head[gi]  = r_mem[r_rd_ptr];

      // Storage is cleared along with the pointers so the data outputs read
      // zero during and right after reset rather than stale words.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
        end else if (w_push[gi]) begin
          r_mem[r_wr_ptr] <= in_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[gi]) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (w_pop[gi]) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
          end
          // Simultaneous push and pop leaves the occupancy unchanged.
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

`ifdef DEMUX_ROUTE_CNT_EN
      logic [31:0] r_cnt;

      // Counts accepted words; wraps from all-ones to zero by plain overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_push[gi]) begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
`endif
    end
  endgenerate

  assign out0_valid = ~w_empty[0];
  assign out0_data  = w_head[0];
  assign out1_valid = ~w_empty[1];
  assign out1_data  = w_head[1];

`ifdef DEMUX_ROUTE_CNT_EN
  assign cnt0 = g_fifo[0].r_cnt;
  assign cnt1 = g_fifo[1].r_cnt;
`endif

endmodule
